// File: rtl/bg_sdr_responder_pkg.sv
// Shared types for the background-layer ROM fetch responder.
//   state_e : responder FSM states
//   chan_e  : requester channel id (A/B), also used as array index
//   DEF_*   : default address/data widths for the SDRAM word port
package bg_sdr_pkg;

    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_e;

    function automatic chan_e other_ch(input chan_e c);
        return (c == CH_A) ? CH_B : CH_A;
    endfunction

endpackage

// File: rtl/bg_sdr_responder_if.sv
// Bundle of the two toggle-handshake request channels and the shared
// level-request SDRAM read port.
//   slave  : responder view (bg_sdr_responder)
//   master : requester + memory view (board side / testbench)
interface bg_sdr_responder_if #(
    parameter int ADDR_W = bg_sdr_pkg::DEF_ADDR_W,
    parameter int DATA_W = bg_sdr_pkg::DEF_DATA_W
);
    logic              req_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] data_a;
    logic              ack_a;
    logic              req_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_b;
    logic              ack_b;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;

    modport slave (
        input  req_a, addr_a, req_b, addr_b, mem_valid, mem_data,
        output data_a, ack_a, data_b, ack_b, mem_req, mem_addr
    );

    modport master (
        output req_a, addr_a, req_b, addr_b, mem_valid, mem_data,
        input  data_a, ack_a, data_b, ack_b, mem_req, mem_addr
    );
endinterface

// File: rtl/bg_sdr_responder_hit_entry.sv
// Single-entry last-address hit register for one request channel.
//   clk_i, rst_ni  : clock, async active-low reset (clears valid)
//   fill_i         : load fill_addr_i/fill_data_i, mark valid
//   cmp_addr_i     : address of the current request
//   hit_o          : entry valid and address matches
//   hit_data_o     : stored data word
module bg_sdr_hit_entry #(
    parameter int ADDR_W = bg_sdr_pkg::DEF_ADDR_W,
    parameter int DATA_W = bg_sdr_pkg::DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_addr_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic [ADDR_W-1:0] cmp_addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] hit_data_o
);
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            addr_q  <= fill_addr_i;
            data_q  <= fill_data_i;
        end
    end

    assign hit_o      = valid_q && (addr_q == cmp_addr_i);
    assign hit_data_o = data_q;
endmodule

// File: rtl/bg_sdr_responder.sv
// Responder for the background tile/pixel ROM fetch interface. Serves the
// A and B toggle-handshake channels from one SDRAM read port, one request
// at a time, with round-robin between channels and an optional per-channel
// last-address hit register.
//   CLK_32M  : system clock
//   RESET_N  : async active-low reset
//   bus      : request channels A/B + SDRAM port (slave modport)
module bg_sdr_responder
    import bg_sdr_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter bit HIT_CACHE = 1'b1
) (
    input  logic                CLK_32M,
    input  logic                RESET_N,
    bg_sdr_responder_if.slave   bus
);
    localparam int NCH = 2;

    state_e                     state_q, state_d;
    chan_e                      ch_q, ch_d;     // channel being served
    chan_e                      rr_q, rr_d;     // preferred channel on a tie
    chan_e                      gnt;
    logic [NCH-1:0]             ack_q, ack_d;
    logic [NCH-1:0]             pend, hit, fill;
    logic [NCH-1:0][DATA_W-1:0] data_q, data_d, hit_data;
    logic [NCH-1:0][ADDR_W-1:0] req_addr;
    logic                       mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d;

    assign pend     = {bus.req_b, bus.req_a} ^ ack_q;
    assign req_addr = {bus.addr_b, bus.addr_a};

    // rr_q names the channel that wins a tie; it moves to the other channel
    // after every completed service, so the last-served channel loses ties.
    assign gnt = (&pend) ? rr_q : (pend[CH_B] ? CH_B : CH_A);

    for (genvar i = 0; i < NCH; i++) begin : g_hit
        if (HIT_CACHE) begin : g_on
            // mem_addr_q still holds the fetched address when mem_valid arrives
            bg_sdr_hit_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_entry (
                .clk_i      (CLK_32M),
                .rst_ni     (RESET_N),
                .fill_i     (fill[i]),
                .fill_addr_i(mem_addr_q),
                .fill_data_i(bus.mem_data),
                .cmp_addr_i (req_addr[i]),
                .hit_o      (hit[i]),
                .hit_data_o (hit_data[i])
            );
        end else begin : g_off
            assign hit[i]      = 1'b0;
            assign hit_data[i] = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        rr_d       = rr_q;
        ack_d      = ack_q;
        data_d     = data_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fill       = '0;
        case (state_q)
            IDLE: begin
                if (|pend) begin
                    ch_d = gnt;
                    if (hit[gnt]) begin
                        data_d[gnt] = hit_data[gnt];
                        state_d     = RESP;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = req_addr[gnt];
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                if (bus.mem_valid) begin
                    mem_req_d    = 1'b0;
                    data_d[ch_q] = bus.mem_data;
                    fill[ch_q]   = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                // data was written on the previous edge, so it is stable
                // by the time the requester sees the ack toggle
                ack_d[ch_q] = ~ack_q[ch_q];
                rr_d        = other_ch(ch_q);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            ch_q       <= CH_A;
            rr_q       <= CH_A;
            ack_q      <= '0;
            data_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            rr_q       <= rr_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.ack_a    = ack_q[CH_A];
    assign bus.ack_b    = ack_q[CH_B];
    assign bus.data_a   = data_q[CH_A];
    assign bus.data_b   = data_q[CH_B];
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
endmodule
